// File: rtl/layer_pipe_reg.sv
// layer_pipe_reg: elastic chain of two-entry skid slices carrying a vector payload plus sideband,
// with registered ready, synchronous flush and an occupancy count.
module layer_pipe_reg #(
    parameter int size = 3,
    parameter int data_size = 16,
    parameter int side_size = 78,
    parameter int depth = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [data_size*size-1:0]     in_data,
    input  logic [side_size-1:0]          in_side,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [data_size*size-1:0]     out_data,
    output logic [side_size-1:0]          out_side,
    output logic [$clog2(2*depth+1)-1:0]  count
);
    localparam int dw = data_size * size + side_size;
    localparam int cw = $clog2(2 * depth + 1);

    logic [depth-1:0] main_v, skid_v, take, drain, dn_rdy, main_load, skid_load;
    logic [dw-1:0] main_d [depth];
    logic [dw-1:0] skid_d [depth];
    logic [dw-1:0] up_d [depth];
    logic in_xfer, out_xfer;

    assign in_ready = ~skid_v[0] & ~flush;
    assign in_xfer = in_valid & in_ready;
    assign out_valid = main_v[depth-1];
    assign out_xfer = out_valid & out_ready;
    assign {out_data, out_side} = main_d[depth-1];

    // each slice only looks at registered neighbour state, so no ready or valid path crosses a slice
    always_comb begin
        up_d[0] = {in_data, in_side};
        take = '0;
        take[0] = in_xfer;
        dn_rdy = '0;
        for (int k = 1; k < depth; k++) begin
            up_d[k] = main_d[k-1];
            take[k] = main_v[k-1] & ~skid_v[k];
        end
        for (int k = 0; k < depth - 1; k++) dn_rdy[k] = ~skid_v[k+1];
        dn_rdy[depth-1] = out_ready;
        drain = main_v & dn_rdy;
        main_load = (drain & skid_v) | (take & (~main_v | drain));
        skid_load = take & main_v & ~drain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= '0;
            skid_v <= '0;
            count <= '0;
            for (int k = 0; k < depth; k++) begin
                main_d[k] <= '0;
                skid_d[k] <= '0;
            end
        end else begin
            main_v <= flush ? '0 : skid_v | take | (main_v & ~drain);
            skid_v <= flush ? '0 : (skid_v & ~drain) | skid_load;
            count <= flush ? '0 : count + cw'(in_xfer) - cw'(out_xfer);
            for (int k = 0; k < depth; k++) begin
                if (main_load[k]) main_d[k] <= skid_v[k] ? skid_d[k] : up_d[k];
                if (skid_load[k]) skid_d[k] <= up_d[k];
            end
        end
    end
endmodule
